// File: rtl/ram_io_responder.sv
// Byte-addressable RAM responder with memory-mapped TX FIFO and halt register.
// Define RAM_IO_RX_EN to add a 4-entry RX FIFO read through the TX/RX port.
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        ram_enable,
   input  logic        lw_type,
   input  logic [31:0] addr,
   input  logic [7:0]  byte_out,
   output logic [7:0]  byte_in,
   output logic        io_buffer_full,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        sim_halt,
   output logic        overflow_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] PORT_ADDR = 32'h0003_0000;
   localparam logic [31:0] HALT_ADDR = 32'h0003_0004;

   logic is_io, is_port, is_halt, st, ld;
   assign is_io   = addr[17:16] == 2'b11;
   assign is_port = addr == PORT_ADDR;
   assign is_halt = addr == HALT_ADDR;
   assign st      = rdy && ram_enable && !lw_type;
   assign ld      = rdy && lw_type;

   logic [7:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk) begin
      if (st && !is_io) mem[addr[ADDR_WIDTH-1:0]] <= byte_out;
   end

   logic [7:0] rx_val;
`ifdef RAM_IO_RX_EN
   logic [7:0] rx_mem [4];
   logic [1:0] rx_wr, rx_rd;
   logic [2:0] rx_cnt, rx_cnt_nxt;
   logic       rx_push, rx_pop, rx_rdy_q;
   assign rx_push    = rx_valid && rx_rdy_q;
   assign rx_pop     = ld && ram_enable && is_port && rx_cnt != 3'd0;
   assign rx_val     = (rx_cnt != 3'd0) ? rx_mem[rx_rd] : 8'h00;
   assign rx_cnt_nxt = rx_cnt + {2'b00, rx_push} - {2'b00, rx_pop};
   assign rx_ready   = rx_rdy_q;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr    <= 2'd0;
         rx_rd    <= 2'd0;
         rx_cnt   <= 3'd0;
         rx_rdy_q <= 1'b0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 2'd1;
         if (rx_pop) rx_rd <= rx_rd + 2'd1;
         rx_cnt   <= rx_cnt_nxt;
         rx_rdy_q <= rx_cnt_nxt != 3'd4;
      end
   end
`else
   logic unused_rx;
   assign unused_rx = ^{rx_data, rx_valid};
   assign rx_val    = 8'h00;
   assign rx_ready  = 1'b0;
`endif

   logic [7:0] io_rd;
   always_comb begin
      io_rd = 8'h00;
      if (is_port) io_rd = rx_val;
      else if (is_halt) io_rd = {7'b0, sim_halt};
   end

   always_ff @(posedge clk) begin
      if (rst) byte_in <= 8'h00;
      else if (ld) byte_in <= is_io ? io_rd : mem[addr[ADDR_WIDTH-1:0]];
   end

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wr, tx_rd;
   logic [CW-1:0] tx_cnt, tx_cnt_nxt;
   logic          tx_push, tx_pop, tx_full, tx_take;
   assign tx_push       = st && is_port;
   assign tx_pop        = uart_tx_valid && uart_tx_ready;
   assign tx_full       = tx_cnt == CW'(FIFO_DEPTH);
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign tx_take       = tx_push && (!tx_full || tx_pop);
   assign tx_cnt_nxt    = tx_cnt + CW'(tx_take) - CW'(tx_pop);
   assign uart_tx_valid = tx_cnt != '0;
   assign uart_tx_data  = uart_tx_valid ? tx_mem[tx_rd] : 8'h00;

   always_ff @(posedge clk) begin
      if (tx_take) tx_mem[tx_wr] <= byte_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr          <= '0;
         tx_rd          <= '0;
         tx_cnt         <= '0;
         io_buffer_full <= 1'b0;
         overflow_err   <= 1'b0;
         sim_halt       <= 1'b0;
      end else begin
         if (tx_take) tx_wr <= tx_wr + PW'(1);
         if (tx_pop) tx_rd <= tx_rd + PW'(1);
         tx_cnt         <= tx_cnt_nxt;
         io_buffer_full <= tx_cnt_nxt >= CW'(FIFO_DEPTH - 2);
         if (tx_push && !tx_take) overflow_err <= 1'b1;
         if (st && is_halt) sim_halt <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ram_io_responder.sv
// Randomised and directed bench for ram_io_responder with a queue-based model.
// Covers the RX FIFO path when RAM_IO_RX_EN is defined.
module tb_ram_io_responder;
   localparam int DEPTH = 8;
   localparam logic [31:0] PORT = 32'h0003_0000;
   localparam logic [31:0] HALT = 32'h0003_0004;

   logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, ram_enable = 1'b0, lw_type = 1'b0;
   logic uart_tx_ready = 1'b0, rx_valid = 1'b0;
   logic [31:0] addr = '0;
   logic [7:0] byte_out = '0, rx_data = '0;
   logic [7:0] byte_in, uart_tx_data;
   logic io_buffer_full, uart_tx_valid, rx_ready, sim_halt, overflow_err;

   ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .ram_enable(ram_enable),
      .lw_type(lw_type), .addr(addr), .byte_out(byte_out),
      .byte_in(byte_in), .io_buffer_full(io_buffer_full),
      .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
      .uart_tx_ready(uart_tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .sim_halt(sim_halt),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int n_tot = 0, n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // Behavioural model: RAM as a sparse byte map, FIFOs as queues.
   logic [7:0] ram [int];
   logic [7:0] txq [$];
   logic [7:0] rxq [$];
   logic [7:0] m_byte = '0, v;
   bit m_known = 1'b1, m_halt = 1'b0, m_ovf = 1'b0, m_full = 1'b0, m_rxrdy = 1'b0;
   bit pop, io, rxpop, rxpush;
   int idx;

   always @(posedge clk) begin
      if (rst) begin
         txq.delete();
         rxq.delete();
         m_byte = '0; m_known = 1'b1; m_halt = 1'b0;
         m_ovf = 1'b0; m_full = 1'b0; m_rxrdy = 1'b0;
      end else begin
         pop = txq.size() != 0 && uart_tx_ready;
         io = addr[17:16] == 2'b11;
         idx = int'(addr[16:0]);
         rxpop = 1'b0;
         if (rdy && lw_type) begin
            if (io) begin
               v = '0;
               if (addr == HALT) v = {7'b0, m_halt};
`ifdef RAM_IO_RX_EN
               if (addr == PORT && rxq.size() != 0) begin
                  v = rxq[0];
                  rxpop = ram_enable;
               end
`endif
               m_byte = v; m_known = 1'b1;
            end else if (ram.exists(idx)) begin
               m_byte = ram[idx]; m_known = 1'b1;
            end else m_known = 1'b0;
         end
         if (rdy && ram_enable && !lw_type) begin
            if (!io) ram[idx] = byte_out;
            else if (addr == PORT) begin
               if (txq.size() < DEPTH || pop) txq.push_back(byte_out);
               else m_ovf = 1'b1;
            end else if (addr == HALT) m_halt = 1'b1;
         end
         if (pop) void'(txq.pop_front());
         m_full = txq.size() >= DEPTH - 2;
`ifdef RAM_IO_RX_EN
         rxpush = rx_valid && m_rxrdy;
         if (rxpush) rxq.push_back(rx_data);
         if (rxpop) void'(rxq.pop_front());
         m_rxrdy = rxq.size() != 4;
`else
         rxpush = 1'b0;
`endif
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_known) chk("m_byte_in", byte_in, m_byte);
         chk("m_tx_valid", uart_tx_valid, txq.size() != 0);
         if (txq.size() != 0) chk("m_tx_data", uart_tx_data, txq[0]);
         chk("m_io_full", io_buffer_full, m_full);
         chk("m_halt", sim_halt, m_halt);
         chk("m_ovf", overflow_err, m_ovf);
         chk("m_rx_ready", rx_ready, m_rxrdy);
      end
   end

   task automatic cyc(bit r, bit en, bit lw, logic [31:0] a, logic [7:0] d);
      rdy = r; ram_enable = en; lw_type = lw; addr = a; byte_out = d;
      @(posedge clk); #1;
      rdy = 1'b1; ram_enable = 1'b0; lw_type = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_byte_in", byte_in, 8'h00);
      chk("rst_tx_valid", uart_tx_valid, 1'b0);
      chk("rst_tx_data", uart_tx_data, 8'h00);
      chk("rst_io_full", io_buffer_full, 1'b0);
      chk("rst_rx_ready", rx_ready, 1'b0);
      chk("rst_halt", sim_halt, 1'b0);
      chk("rst_ovf", overflow_err, 1'b0);
      rst = 1'b0;
      chk_en = 1'b1;

      cyc(1, 1, 0, 32'h10, 8'hA5);
      cyc(1, 0, 1, 32'h10, 8'h00);
      @(negedge clk);
      chk("load_a5", byte_in, 8'hA5);

      uart_tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, PORT, 8'(8'h10 + i));
         @(negedge clk);
         chk("full_rise", io_buffer_full, i == 5);
      end
      chk("head_first", uart_tx_data, 8'h10);
      chk("valid_six", uart_tx_valid, 1'b1);
      for (int i = 6; i < 9; i++) cyc(1, 1, 0, PORT, 8'(8'h10 + i));
      @(negedge clk);
      chk("ovf_ninth", overflow_err, 1'b1);
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_order", uart_tx_data, 8'(8'h10 + i));
         chk("drain_full", io_buffer_full, i < 3);
         @(negedge clk);
      end
      chk("drain_empty", uart_tx_valid, 1'b0);

      uart_tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, PORT, 8'(8'h50 + i));
      uart_tx_ready = 1'b1;
      cyc(1, 1, 0, PORT, 8'h53);
      uart_tx_ready = 1'b0;
      @(negedge clk);
      chk("pushpop_head", uart_tx_data, 8'h51);
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pushpop_order", uart_tx_data, 8'(8'h51 + i));
         @(negedge clk);
      end
      chk("pushpop_cnt3", uart_tx_valid, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0, PORT, 8'(8'h80 + i));
         @(negedge clk);
         chk("wrap_stream", uart_tx_data, 8'(8'h80 + i));
      end

      cyc(1, 1, 0, 32'h20, 8'h11);
      cyc(1, 0, 1, 32'h20, 8'h00);
      @(negedge clk);
      chk("load_11", byte_in, 8'h11);
      cyc(0, 1, 0, 32'h20, 8'h77);
      cyc(0, 0, 1, 32'h10, 8'h00);
      @(negedge clk);
      chk("hold_rdy0", byte_in, 8'h11);
      cyc(1, 0, 1, 32'h20, 8'h00);
      @(negedge clk);
      chk("ram_unchanged", byte_in, 8'h11);
      cyc(1, 1, 0, 32'h2_0010, 8'h3C);
      cyc(1, 0, 1, 32'h10, 8'h00);
      @(negedge clk);
      chk("alias_17bit", byte_in, 8'h3C);
      cyc(1, 1, 0, 32'h3_0008, 8'hFF);
      cyc(1, 0, 1, 32'h3_0008, 8'h00);
      @(negedge clk);
      chk("io_other", byte_in, 8'h00);
      cyc(1, 1, 0, HALT, 8'h01);
      @(negedge clk);
      chk("halt_set", sim_halt, 1'b1);
      cyc(1, 0, 1, HALT, 8'h00);
      @(negedge clk);
      chk("halt_read", byte_in, 8'h01);

      uart_tx_ready = 1'b0;
      cyc(1, 1, 0, PORT, 8'hC1);
      cyc(1, 1, 0, PORT, 8'hC2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_halt", sim_halt, 1'b0);
      chk("rst2_valid", uart_tx_valid, 1'b0);
      chk("rst2_byte_in", byte_in, 8'h00);
      cyc(1, 1, 0, PORT, 8'hD1);
      @(negedge clk);
      chk("rst2_discard", uart_tx_data, 8'hD1);
      uart_tx_ready = 1'b1;

      cyc(1, 0, 1, 32'h10, 8'h00);
`ifdef RAM_IO_RX_EN
      rx_data = 8'h41; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      cyc(1, 1, 1, PORT, 8'h00);
      @(negedge clk);
      chk("rx_load", byte_in, 8'h41);
      cyc(1, 1, 1, PORT, 8'h00);
      @(negedge clk);
      chk("rx_empty", byte_in, 8'h00);
`else
      cyc(1, 1, 1, PORT, 8'h00);
      @(negedge clk);
      chk("rx_off_load", byte_in, 8'h00);
      chk("rx_off_ready", rx_ready, 1'b0);
`endif

      for (int i = 0; i < 1500; i++) begin
         rdy = $urandom_range(0, 7) != 0;
         ram_enable = 1'($urandom_range(0, 1));
         lw_type = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 11))
            0, 1, 2: addr = PORT;
            3: addr = 32'h3_0008;
            4: addr = 32'h2_0100 + 32'($urandom_range(0, 15));
            5: addr = (i > 1200) ? HALT : 32'h3_000C;
            default: addr = 32'h100 + 32'($urandom_range(0, 15));
         endcase
         byte_out = 8'($urandom);
         rx_data = 8'($urandom);
         rx_valid = $urandom_range(0, 2) == 0;
         uart_tx_ready = (i < 750) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      ram_enable = 1'b0; lw_type = 1'b0; rx_valid = 1'b0;
      uart_tx_ready = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("final_drained", uart_tx_valid, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
